scan_ctrl: RTL and testbench

SCAN_CTRL -- requirements
Module: scan_ctrl

---
 rtl/scan_ctrl.sv | 148 ++++++++++++++
 tb/tb_scan_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_ctrl.sv
// Scan-chain test controller: loads a pattern into an external FF_scan chain,
// pulses one capture cycle, unloads the response and compares it to a golden vector.
module scan_ctrl #(
    parameter int unsigned CHAIN_LEN = 8
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic                 SO,
    output logic                 SE,
    output logic                 SI,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CHAIN_LEN-1:0] captured
);

    localparam int unsigned CW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN_LEN - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SHIFT_IN  = 3'd1;
    localparam logic [2:0] S_CAPTURE   = 3'd2;
    localparam logic [2:0] S_SHIFT_OUT = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] pat_q, pat_d;
    logic [CHAIN_LEN-1:0] exp_q, exp_d;
    logic [CHAIN_LEN-1:0] cap_q, cap_d;
    logic                 pass_q, pass_d;
    logic                 se_q, se_d;
    logic                 si_q, si_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Next-state, counter and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        exp_d   = exp_q;
        cap_d   = cap_q;
        pass_d  = pass_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pat_d   = pattern;
                    exp_d   = expected;
                    cap_d   = '0;
                    pass_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_SHIFT_IN;
                end
            end
            S_SHIFT_IN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CAPTURE: begin
                cnt_d   = '0;
                state_d = S_SHIFT_OUT;
            end
            S_SHIFT_OUT: begin
                // First bit out is the last cell, so fill captured from the MSB down
                for (int i = 0; i < CHAIN_LEN; i++) begin
                    if (cnt_q == CW'(CHAIN_LEN - 1 - i)) begin
                        cap_d[i] = SO;
                    end
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                // Unknown captured bits fall through to the default of 0
                pass_d = 1'b0;
                if (cap_q == exp_q) begin
                    pass_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control outputs decoded from the next registered state so they leave a flop
    always_comb begin
        se_d   = (state_d == S_SHIFT_IN) || (state_d == S_SHIFT_OUT);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        si_d   = 1'b0;
        if (state_d == S_SHIFT_IN) begin
            for (int i = 0; i < CHAIN_LEN; i++) begin
                if (cnt_d == CW'(CHAIN_LEN - 1 - i)) begin
                    si_d = pat_d[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pat_q   <= '0;
            exp_q   <= '0;
            cap_q   <= '0;
            pass_q  <= 1'b0;
            se_q    <= 1'b0;
            si_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            exp_q   <= exp_d;
            cap_q   <= cap_d;
            pass_q  <= pass_d;
            se_q    <= se_d;
            si_q    <= si_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign SE       = se_q;
    assign SI       = si_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign captured = cap_q;

endmodule

// File: tb/tb_scan_ctrl.sv
// Bench for scan_ctrl driving an 8-cell FF_scan chain with inverters between
// cells (cell 0 D tied high); expected responses queued at launch, checked at done.
module tb_scan_ctrl;

    localparam int unsigned N = 8;

    typedef struct packed {
        logic [N-1:0] cap;
        logic         pass;
    } exp_t;

    logic         clk      = 1'b0;
    logic         reset_L  = 1'b0;
    logic         start    = 1'b0;
    logic [N-1:0] pattern  = '0;
    logic [N-1:0] expected = '0;
    logic [N-1:0] chain    = '0;
    logic         SO, SE, SI, busy, done, pass;
    logic [N-1:0] captured;

    int   cyc   = 0;
    int   t0    = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    scan_ctrl #(.CHAIN_LEN(N)) dut (
        .clk      (clk),
        .reset_L  (reset_L),
        .start    (start),
        .pattern  (pattern),
        .expected (expected),
        .SO       (SO),
        .SE       (SE),
        .SI       (SI),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .captured (captured)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Chain under test: shift when SE, else capture inverted neighbour
    always @(posedge clk) chain <= SE ? {chain[N-2:0], SI} : {~chain[N-2:0], 1'b1};
    assign SO = chain[N-1];

    function automatic logic [N-1:0] model_cap(input logic [N-1:0] p);
        return {~p[N-2:0], 1'b1};
    endfunction

    // Caller is at a negedge; returns just after the accepting edge (cycle 1)
    task automatic launch(input logic [N-1:0] p, input logic [N-1:0] e);
        exp_t x;
        pattern  = p;
        expected = e;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        t0     = cyc;
        x.cap  = model_cap(p);
        x.pass = (model_cap(p) == e);
        sb.push_back(x);
    endtask

    task automatic wait_done(output int dcyc);
        dcyc = -1;
        for (int i = 0; i < 60 && dcyc < 0; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcyc = cyc - t0 + 1;
        end
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        start   = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({SE, SI, busy, done, pass, captured} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got SE=%b SI=%b busy=%b done=%b pass=%b cap=%h expected all 0",
                     SE, SI, busy, done, pass, captured);
        end
        reset_L = 1'b1;
        start   = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL start_during_reset: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_pattern(input logic [N-1:0] p, input logic [N-1:0] e);
        exp_t         x;
        int           dcyc;
        logic [N-1:0] si_seq;
        logic         se_all;
        si_seq = '0;
        se_all = 1'b1;
        @(negedge clk);
        launch(p, e);
        for (int c = 0; c < N; c++) begin
            @(negedge clk);
            si_seq = {si_seq[N-2:0], SI};
            se_all = se_all & SE & busy;
        end
        n_cmp++;
        if (si_seq !== p || se_all !== 1'b1) begin
            n_err++;
            $display("FAIL shift_in_%h: SI seq %h SE/busy %b expected %h / 1", p, si_seq, se_all, p);
        end
        wait_done(dcyc);
        x = sb.pop_front();
        n_cmp++;
        if (dcyc != 2 * N + 2) begin
            n_err++;
            $display("FAIL done_cycle_%h: got %0d expected %0d", p, dcyc, 2 * N + 2);
        end
        n_cmp++;
        if (captured !== x.cap) begin
            n_err++;
            $display("FAIL captured_%h: got %h expected %h", p, captured, x.cap);
        end
        @(negedge clk);
        n_cmp++;
        if (pass !== x.pass || {busy, done, SE} !== 3'b000) begin
            n_err++;
            $display("FAIL pass_%h: got pass=%b busy=%b done=%b SE=%b expected pass=%b, rest 0",
                     p, pass, busy, done, SE, x.pass);
        end
    endtask

    task automatic test_ignore_start();
        exp_t         x;
        int           k;
        int           ndone;
        int           dcyc;
        @(negedge clk);
        launch(8'hA5, 8'hB5);
        ndone = 0;
        dcyc  = -1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            k = cyc - t0 + 1;
            if (done === 1'b1) begin
                ndone++;
                if (dcyc < 0) dcyc = k;
            end
            start = (k == 3 || k == 12);
            if (k == 5) begin
                pattern  = '0;
                expected = '0;
            end
        end
        start = 1'b0;
        x = sb.pop_front();
        n_cmp++;
        if (ndone != 1 || dcyc != 2 * N + 2) begin
            n_err++;
            $display("FAIL ignore_start_done: pulses %0d at cycle %0d expected 1 at %0d", ndone, dcyc, 2 * N + 2);
        end
        n_cmp++;
        if (captured !== x.cap || pass !== x.pass) begin
            n_err++;
            $display("FAIL ignore_start_result: got cap=%h pass=%b expected cap=%h pass=%b",
                     captured, pass, x.cap, x.pass);
        end
    endtask

    task automatic test_reset_mid();
        exp_t x;
        int   dcyc;
        @(negedge clk);
        launch(8'h3C, 8'h00);
        repeat (12) @(negedge clk);
        reset_L = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({SE, busy, done, pass, captured} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_shift: got SE=%b busy=%b done=%b pass=%b cap=%h expected all 0",
                     SE, busy, done, pass, captured);
        end
        reset_L = 1'b1;
        x = sb.pop_front();
        launch(8'h00, 8'hFF);
        wait_done(dcyc);
        x = sb.pop_front();
        n_cmp++;
        if (dcyc != 2 * N + 2 || captured !== x.cap) begin
            n_err++;
            $display("FAIL after_reset_test: done cycle %0d cap %h expected %0d / %h", dcyc, captured, 2 * N + 2, x.cap);
        end
        @(negedge clk);
        n_cmp++;
        if (pass !== x.pass) begin
            n_err++;
            $display("FAIL after_reset_pass: got %b expected %b", pass, x.pass);
        end
    endtask

    task automatic test_back_to_back();
        exp_t x;
        int   dcyc;
        @(negedge clk);
        launch(8'hFF, 8'h01);
        wait_done(dcyc);
        x = sb.pop_front();
        @(negedge clk);
        n_cmp++;
        if (pass !== x.pass || captured !== x.cap || busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_first: got pass=%b cap=%h busy=%b expected pass=%b cap=%h busy=0",
                     pass, captured, busy, x.pass, x.cap);
        end
        launch(8'h00, 8'hFF);
        n_cmp++;
        if (pass !== 1'b0 || busy !== 1'b1 || captured !== '0) begin
            n_err++;
            $display("FAIL b2b_accept: got pass=%b busy=%b cap=%h expected 0 / 1 / 00", pass, busy, captured);
        end
        wait_done(dcyc);
        x = sb.pop_front();
        n_cmp++;
        if (dcyc != 2 * N + 2 || captured !== x.cap) begin
            n_err++;
            $display("FAIL b2b_second: done cycle %0d cap %h expected %0d / %h", dcyc, captured, 2 * N + 2, x.cap);
        end
        @(negedge clk);
        n_cmp++;
        if (pass !== x.pass) begin
            n_err++;
            $display("FAIL b2b_second_pass: got %b expected %b", pass, x.pass);
        end
    endtask

    initial begin
        test_reset();
        test_pattern(8'h00, 8'hFF);
        test_pattern(8'hA5, 8'hB5);
        test_pattern(8'hFF, 8'h00);
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
